// File: rtl/riscv_pkg.sv
// Shared fetch/decode definitions: word width, canonical NOP and the fetch packet.
package riscv_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;
endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID instruction queue.
interface if_id_queue_if
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  pc_i;
  logic [XLEN-1:0]  instr_i;
  logic             valid_i;
  logic             ready_o;
  logic             flush_i;
  logic [XLEN-1:0]  pc_o;
  logic [XLEN-1:0]  instr_o;
  logic             valid_o;
  logic             ready_i;
  logic [CNT_W-1:0] count_o;

  modport slave (
    input  pc_i, instr_i, valid_i, flush_i, ready_i,
    output ready_o, pc_o, instr_o, valid_o, count_o
  );

  modport master (
    output pc_i, instr_i, valid_i, flush_i, ready_i,
    input  ready_o, pc_o, instr_o, valid_o, count_o
  );
endinterface

// File: rtl/if_id_queue_mem.sv
// Queue storage: DEPTH fetch packets, one write port, asynchronous read, no reset.
module if_id_queue_mem
  import riscv_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  fetch_pkt_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output fetch_pkt_t    rdata_o
);
  fetch_pkt_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/if_id_queue.sv
// Elastic IF/ID instruction queue: circular FIFO with valid/ready on both sides and one-cycle flush.
module if_id_queue
  import riscv_pkg::*;
#(
  parameter  int unsigned XLEN  = riscv_pkg::XLEN,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic      clk_i,
  input  logic      resetn_i,
  if_id_queue_if.slave q
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             can_push, can_pop, push, pop;
  fetch_pkt_t       wr_pkt, rd_pkt;
  logic [XLEN-1:0]  head_pc, head_instr;

  // Handshakes depend only on registered occupancy, so ready_o never sees ready_i.
  assign can_push = (count_q != CNT_W'(DEPTH));
  assign can_pop  = (count_q != '0);
  assign push     = q.valid_i & can_push;
  assign pop      = can_pop & q.ready_i;

  assign wr_pkt.pc    = q.pc_i;
  assign wr_pkt.instr = q.instr_i;

  if_id_queue_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (push & ~q.flush_i),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_pkt),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_pkt)
  );

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (q.flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Empty queue presents a harmless NOP at pc 0 rather than stale storage.
  always_comb begin
    head_pc    = '0;
    head_instr = XLEN'(NOP_INSTR);
    if (can_pop) begin
      head_pc    = rd_pkt.pc;
      head_instr = rd_pkt.instr;
    end
  end

  assign q.pc_o    = head_pc;
  assign q.instr_o = head_instr;
  assign q.valid_o = can_pop;
  assign q.ready_o = can_push;
  assign q.count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (resetn_i) begin
      assert (!$isunknown(q.valid_i))
        else $error("if_id_queue: valid_i unknown");
      assert (count_q <= CNT_W'(DEPTH))
        else $error("if_id_queue: occupancy above DEPTH");
      assert (!(pop && count_q == '0))
        else $error("if_id_queue: pop from empty queue");
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Randomised scoreboard bench for if_id_queue against a queue-based reference model.
module tb_if_id_queue;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  logic  clk    = 1'b0;
  logic  resetn = 1'b1;
  item_t exp_q[$];
  int    n_vec  = 0;
  int    n_err  = 0;

  if_id_queue_if #(.DEPTH(DEPTH)) q ();

  if_id_queue #(
    .XLEN (32),
    .DEPTH(DEPTH)
  ) dut (
    .clk_i   (clk),
    .resetn_i(resetn),
    .q       (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Occupancy-derived outputs predicted from the number of words the model holds.
  task automatic check_state();
    chk("count_o", 64'(q.count_o), 64'(exp_q.size()));
    chk("ready_o", 64'(q.ready_o), 64'(exp_q.size() != DEPTH));
    chk("valid_o", 64'(q.valid_o), 64'(exp_q.size() != 0));
  endtask

  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    check_state();
    q.valid_i = v;
    q.pc_i    = pc;
    q.instr_i = ins;
    q.ready_i = rdy;
    q.flush_i = fl;
    if (v && !fl && exp_q.size() < DEPTH) exp_q.push_back('{pc, ins});
  endtask

  task automatic idle_inputs();
    q.valid_i = 1'b0;
    q.pc_i    = '0;
    q.instr_i = '0;
    q.ready_i = 1'b0;
    q.flush_i = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_valid"}, 64'(q.valid_o), 64'd0);
    chk({tag, "_ready"}, 64'(q.ready_o), 64'd1);
    chk({tag, "_count"}, 64'(q.count_o), 64'd0);
    chk({tag, "_instr"}, 64'(q.instr_o), 64'h13);
    chk({tag, "_pc"},    64'(q.pc_o),    64'd0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    reset_checks("midrst");
    exp_q.delete();
    idle_inputs();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Monitor: compares the presented head against the scoreboard and retires consumed words.
  always @(negedge clk) begin
    if (resetn) begin
      if (q.valid_o) begin
        if (exp_q.size() == 0) begin
          chk("head_unexpected", 64'(q.valid_o), 64'd0);
        end else begin
          chk("head_pc",    64'(q.pc_o),    64'(exp_q[0].pc));
          chk("head_instr", 64'(q.instr_o), 64'(exp_q[0].instr));
        end
      end else begin
        chk("empty_pc",    64'(q.pc_o),    64'd0);
        chk("empty_instr", 64'(q.instr_o), 64'h13);
      end
      if (q.flush_i) exp_q.delete();
      else if (q.valid_o && q.ready_i && exp_q.size() != 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    int unsigned pv, pr;
    idle_inputs();
    #2 resetn = 1'b0;
    #1 reset_checks("por");
    @(posedge clk);
    #1 resetn = 1'b1;

    cycle(1'b1, 32'h0, 32'h0050_0093, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), $urandom, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 32'h10, 32'hdead_beef, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    cycle(1'b1, 32'h10, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h14, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h18, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h1c, $urandom, 1'b1, 1'b1);
    cycle(1'b1, 32'h40, 32'h0010_0113, 1'b0, 1'b0);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h100 + 32'(i * 4), $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h200, $urandom, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h300 + 32'(i * 4), $urandom, 1'b0, 1'b0);
    mid_reset();
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    for (int ph = 0; ph < 6; ph++) begin
      pv = $urandom_range(20, 95);
      pr = $urandom_range(20, 95);
      for (int i = 0; i < 250; i++)
        cycle($urandom_range(0, 99) < pv, $urandom & 32'hffff_fffc, $urandom,
              $urandom_range(0, 99) < pr, $urandom_range(0, 39) == 0);
    end

    repeat (DEPTH + 3) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Elastic instruction queue between the instruction fetch stage and the decode stage.
- Captures {pc, instr} pairs from fetch and holds them in a small circular FIFO.
- Presents them to decode with a valid/ready handshake, absorbing decode stalls without dropping fetched words.
- A flush input, driven by taken branches or redirects, discards all queued wrong-path instructions in one cycle.

Parameters:
- XLEN, 32, width of PC and instruction words.
- DEPTH, 4, number of queue entries; must be a power of two and >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived; do not override).

Ports:
- clk_i  input  1  system clock.
- resetn_i  input  1  asynchronous active-low reset.
- pc_i  input  XLEN  PC of the incoming instruction from fetch.
- instr_i  input  XLEN  incoming instruction word from fetch.
- valid_i  input  1  fetch presents a valid {pc_i, instr_i}.
- ready_o  output  1  queue can accept a word this cycle.
- flush_i  input  1  discard all queued entries (branch taken / redirect).
- pc_o  output  XLEN  PC of the head entry, to decode.
- instr_o  output  XLEN  instruction at the head entry, to decode.
- valid_o  output  1  head entry valid.
- ready_i  input  1  decode consumes the head entry this cycle.
- count_o  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low, asserted on resetn_i low with immediate effect, and released synchronously to clk_i.
- Reset values:
  - wr_ptr = rd_ptr = 0, count_o = 0
  - valid_o = 0, ready_o = 1
  - pc_o = 0, instr_o = NOP_INSTR (32'h0000_0013)
  - Storage array contents are not reset.
- Push occurs when valid_i & ready_o. The entry is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop occurs when valid_o & ready_i. rd_ptr increments modulo DEPTH.
- ready_o = (count_o != DEPTH). It is a pure function of registered state, with no combinational path from ready_i.
- valid_o = (count_o != 0). pc_o/instr_o are driven from entry[rd_ptr] when valid_o=1. When empty they are forced to pc 0 / NOP_INSTR.
- Latency: a word pushed into an empty queue appears on valid_o the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - When full, ready_o=0, so no push can occur; a pop that cycle frees a slot visible the following cycle.
  - When empty, valid_o=0, so no pop can occur; a push becomes visible the next cycle.
- Counter: count_o += push, -= pop. It is never allowed to exceed DEPTH or go below 0. An assertion flags either condition.
- Flush (synchronous, highest priority):
  - On a cycle with flush_i=1, the next state is wr_ptr=rd_ptr=0, count_o=0, valid_o=0.
  - Any push or pop in the flush cycle is discarded.
  - Handshake signals are still evaluated combinationally that cycle, but no entry survives.
  - Flush held across several cycles keeps the queue empty.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy comes from count, not pointer comparison.
- Reset mid-operation: all state returns immediately to reset values. In-flight handshakes are lost; fetch must re-issue from its reset PC.
- Unknown inputs: valid_i=X outside reset is an assertion error. instr_i/pc_i are don't-care when valid_i=0.

Decomposition:
- The shared package (riscv_pkg) holds:
  - XLEN
  - NOP_INSTR (32'h0000_0013, addi x0,x0,0)
  - typedef fetch_pkt_t = struct {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;}
- Storage is a natural sub-module: if_id_queue_mem, a DEPTH x fetch_pkt_t register array with one write port and one asynchronous read port, no reset.
- Pointer, counter and flush control stay in if_id_queue.

Test Plan:
- Reset then idle: resetn_i low asynchronously mid-cycle -> valid_o=0, ready_o=1, count_o=0, instr_o=32'h13 immediately, before the next edge.
- Single pass: push pc=0x0, instr=0x00500093 with ready_i=1 -> valid_o=1 next cycle with the same pc/instr; count returns to 0 the cycle after the pop.
- Fill and stall: ready_i=0, push pcs 0x0,0x4,0x8,0xC -> count_o=4, ready_o=0. A 5th word held on valid_i is not accepted. Release ready_i -> words pop in order 0x0..0xC.
- Wrap-around: sustained push+pop with ready_i=1 for 10 words (pcs 0x0..0x24) -> output order matches input, count_o stays 1, pointers wrap twice without loss.
- Flush with simultaneous push: queue holds 0x10,0x14,0x18; assert flush_i together with a push of 0x1C -> next cycle count_o=0, valid_o=0. A following push of 0x40 emerges as the head.
- Full with concurrent pop: queue full, ready_i=1 -> ready_o=0 that cycle, ready_o=1 the next cycle, count_o=3.
